// File: rtl/cluster_priority_multi.sv
// Extracts up to MXCLUSTERS valid pads per frame, in ascending pad order, with their count words.
// Latency: pads sampled at latch edge E are published at edge E+PHASES; frame_done pulses for one cycle.
// Backpressure: none; the packer must accept the list every PHASES clocks.
module cluster_priority_multi #(
  parameter int MXPADS     = 1536,
  parameter int MXADRBITS  = 11,
  parameter int MXCNTBITS  = 3,
  parameter int MXCLUSTERS = 4,
  parameter int PHASES     = 8,
  parameter logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FE
) (
  input  logic                            clock,
  input  logic                            global_reset,
  input  logic [MXPADS-1:0]               vpfs,
  input  logic [MXPADS*MXCNTBITS-1:0]     cnts,
  output logic [MXCLUSTERS*MXADRBITS-1:0] adr,
  output logic [MXCLUSTERS*MXCNTBITS-1:0] cnt,
  output logic [MXCLUSTERS-1:0]           vld,
  output logic                            frame_done,
  output logic                            overflow
);

  localparam int PW     = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int KW     = $clog2(MXCLUSTERS) + 1;
  localparam int LEVELS = $clog2(MXPADS);
  localparam int NLEAF  = 1 << LEVELS;

  logic [PW-1:0]                  r_phase;
  logic                           r_primed;   // a full frame has been searched since reset
  logic [MXPADS-1:0]              r_work_mask;
  logic [MXPADS*MXCNTBITS-1:0]    r_cnt_latch;
  logic [KW-1:0]                  r_k;
  logic [MXADRBITS-1:0]           r_sc_adr [MXCLUSTERS];
  logic [MXCNTBITS-1:0]           r_sc_cnt [MXCLUSTERS];
  logic [MXCLUSTERS-1:0]          r_sc_vld;
  logic [MXCLUSTERS*MXADRBITS-1:0] r_adr;
  logic [MXCLUSTERS*MXCNTBITS-1:0] r_cnt;
  logic [MXCLUSTERS-1:0]          r_vld;
  logic                           r_frame_done;
  logic                           r_overflow;

  logic                           w_any;
  logic [MXADRBITS-1:0]           w_p;
  logic [MXCNTBITS-1:0]           w_pcnt;
  logic                           w_latch;
  logic                           w_search;

  // Balanced 2:1 lowest-set-bit tree; leaves beyond MXPADS are tied invalid.
  // At each node the left (lower-index) child wins when valid.
  genvar l, n;
  for (l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = NLEAF >> l;
    logic [N-1:0]         w_v;
    logic [MXADRBITS-1:0] w_i [N];
    for (n = 0; n < N; n++) begin : g_node
      if (l == 0) begin : g_leaf
        if (n < MXPADS) begin : g_real
          assign w_v[n] = r_work_mask[n];
        end else begin : g_pad
          assign w_v[n] = 1'b0;
        end
        assign w_i[n] = MXADRBITS'(n);
      end else begin : g_inner
        assign w_v[n] = g_lvl[l-1].w_v[2*n] | g_lvl[l-1].w_v[2*n+1];
        assign w_i[n] = g_lvl[l-1].w_v[2*n] ? g_lvl[l-1].w_i[2*n] : g_lvl[l-1].w_i[2*n+1];
      end
    end
  end

  assign w_any    = g_lvl[LEVELS].w_v[0];
  assign w_p      = g_lvl[LEVELS].w_i[0];
  assign w_pcnt   = r_cnt_latch[w_p*MXCNTBITS +: MXCNTBITS];
  assign w_latch  = (r_phase == '0);
  assign w_search = (r_phase != '0) && (r_phase <= PW'(MXCLUSTERS));

  // Phase counter, latch/publish, one extraction per search edge, idle hold.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      r_phase      <= '0;
      r_primed     <= 1'b0;
      r_work_mask  <= '0;
      r_cnt_latch  <= '0;
      r_k          <= '0;
      r_sc_vld     <= '0;
      for (int s = 0; s < MXCLUSTERS; s++) begin
        r_sc_adr[s] <= INVALID_ADR;
        r_sc_cnt[s] <= '0;
      end
      r_adr        <= {MXCLUSTERS{INVALID_ADR}};
      r_cnt        <= '0;
      r_vld        <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_phase      <= (r_phase == PW'(PHASES-1)) ? '0 : r_phase + 1'b1;
      r_frame_done <= 1'b0;
      if (w_latch) begin
        // Publish the previous frame's scratch in the same edge the next frame is latched.
        if (r_primed) begin
          for (int s = 0; s < MXCLUSTERS; s++) begin
            r_adr[s*MXADRBITS +: MXADRBITS] <= r_sc_adr[s];
            r_cnt[s*MXCNTBITS +: MXCNTBITS] <= r_sc_cnt[s];
          end
          r_vld        <= r_sc_vld;
          r_overflow   <= |r_work_mask;
          r_frame_done <= 1'b1;
        end
        r_primed    <= 1'b1;
        r_work_mask <= vpfs;
        r_cnt_latch <= cnts;
        r_k         <= '0;
      end else if (w_search) begin
        for (int s = 0; s < MXCLUSTERS; s++) begin
          if (r_k == KW'(s)) begin
            r_sc_vld[s] <= w_any;
            r_sc_adr[s] <= w_any ? w_p : INVALID_ADR;
            r_sc_cnt[s] <= w_any ? w_pcnt : '0;
          end
        end
        if (w_any) begin
          r_work_mask[w_p] <= 1'b0;
        end
        r_k <= r_k + 1'b1;
      end
    end
  end

  assign adr        = r_adr;
  assign cnt        = r_cnt;
  assign vld        = r_vld;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_cluster_priority_multi.sv
// Directed bench for cluster_priority_multi with a frame-level reference model.
// The model sorts each latched frame in one step and publishes it one frame later.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_cluster_priority_multi;

  localparam int NP = 1536;
  localparam int AB = 11;
  localparam int CB = 3;
  localparam int NC = 4;
  localparam int PH = 8;
  localparam logic [AB-1:0] INV = 11'h7FE;

  logic                 clock = 1'b0;
  logic                 global_reset;
  logic [NP-1:0]        vpfs;
  logic [NP*CB-1:0]     cnts;
  logic [NC*AB-1:0]     adr;
  logic [NC*CB-1:0]     cnt;
  logic [NC-1:0]        vld;
  logic                 frame_done;
  logic                 overflow;

  int n_err = 0;
  int n_chk = 0;

  cluster_priority_multi dut (
    .clock(clock), .global_reset(global_reset), .vpfs(vpfs), .cnts(cnts),
    .adr(adr), .cnt(cnt), .vld(vld), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase tracking and whole-frame sort at the latch edge.
  int              m_phase = 0;
  bit              m_primed = 0;
  bit              m_started = 0;
  logic [NC*AB-1:0] e_adr, p_adr;
  logic [NC*CB-1:0] e_cnt, p_cnt;
  logic [NC-1:0]    e_vld, p_vld;
  logic             e_ovf, p_ovf, e_fd;

  always @(posedge clock) begin
    int found;
    m_started = 1;
    if (global_reset) begin
      m_phase = 0; m_primed = 0;
      e_adr = {NC{INV}}; e_cnt = '0; e_vld = '0; e_ovf = 0; e_fd = 0;
    end else begin
      e_fd = 0;
      if (m_phase == 0) begin
        if (m_primed) begin
          e_adr = p_adr; e_cnt = p_cnt; e_vld = p_vld; e_ovf = p_ovf; e_fd = 1;
        end
        m_primed = 1;
        found = 0;
        p_adr = {NC{INV}}; p_cnt = '0; p_vld = '0;
        for (int i = 0; i < NP; i++) begin
          if (vpfs[i]) begin
            if (found < NC) begin
              p_adr[found*AB +: AB] = AB'(i);
              p_cnt[found*CB +: CB] = cnts[i*CB +: CB];
              p_vld[found] = 1'b1;
            end
            found++;
          end
        end
        p_ovf = (found > NC);
      end
      m_phase = (m_phase + 1) % PH;
    end
  end

  // Compare every cycle once the model has seen an edge.
  always @(negedge clock) begin
    if (m_started) begin
      chk("list", {vld, cnt, adr}, {e_vld, e_cnt, e_adr});
      chk("overflow", 64'(overflow), 64'(e_ovf));
      chk("frame_done", 64'(frame_done), 64'(e_fd));
    end
  end

  // Stop on the falling edge whose following rising edge has phase p.
  task automatic wait_phase(input int p);
    bit ok = 0;
    for (int t = 0; t <= PH; t++) begin
      if (m_phase == p) begin ok = 1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL wait_phase: phase %0d never reached", p);
    end
  endtask

  // Present a frame at its latch edge; afterwards cnts are scrambled to prove latch-only sampling.
  task automatic next_frame(input logic [NP-1:0] vp, input logic [NP*CB-1:0] cn);
    wait_phase(0);
    vpfs = vp; cnts = cn;
    @(negedge clock);
    vpfs = '0; cnts = ~cn;
  endtask

  logic [NP-1:0]    fv;
  logic [NP*CB-1:0] fc;

  task automatic set_pad(input int i, input int c);
    fv[i] = 1'b1;
    fc[i*CB +: CB] = CB'(c);
  endtask

  initial begin
    global_reset = 1'b1; vpfs = '0; cnts = '0;
    repeat (3) @(negedge clock);
    chk("reset_adr", 64'(adr), 64'({NC{INV}}));
    chk("reset_misc", {vld, cnt, frame_done, overflow}, '0);
    global_reset = 1'b0;

    // Empty frames: first frame after reset has no strobe.
    next_frame('0, '0);
    chk("first_no_strobe", 64'(frame_done), 64'd0);
    next_frame('0, '0);
    chk("empty_publish", {frame_done, overflow, vld}, {1'b1, 1'b0, 4'b0000});
    chk("empty_adr", 64'(adr), 64'({NC{INV}}));

    // Sorting.
    fv = '0; fc = '0;
    set_pad(1535, 5); set_pad(7, 1); set_pad(800, 3);
    next_frame(fv, fc);
    // Overflow frame.
    fv = '0; fc = '0;
    for (int i = 0; i < 5; i++) set_pad(i, i + 1);
    set_pad(1000, 7);
    next_frame(fv, fc);
    chk("sort_adr", 64'(adr), 64'({INV, 11'd1535, 11'd800, 11'd7}));
    chk("sort_cnt_vld", {vld, cnt}, {4'b0111, 3'd0, 3'd5, 3'd3, 3'd1});
    chk("sort_ovf", 64'(overflow), 64'd0);

    // Two-pad frame clears overflow.
    fv = '0; fc = '0;
    set_pad(100, 2); set_pad(200, 4);
    next_frame(fv, fc);
    chk("ovf_adr", 64'(adr), 64'({11'd3, 11'd2, 11'd1, 11'd0}));
    chk("ovf_cnt_vld", {vld, cnt, overflow}, {4'b1111, 3'd4, 3'd3, 3'd2, 3'd1, 1'b1});

    // Sampling window: pad 10 at latch only, pad 20 and a cnt change at phase 3.
    fv = '0; fc = '0;
    set_pad(10, 6);
    next_frame(fv, fc);
    chk("two_pad", {vld, overflow, adr[2*AB-1:0]}, {4'b0011, 1'b0, 11'd200, 11'd100});
    wait_phase(3);
    vpfs[20] = 1'b1; cnts[10*CB +: CB] = 3'd2;
    @(negedge clock);
    vpfs = '0;

    // Back-to-back A then B.
    fv = '0; fc = '0;
    set_pad(5, 1);
    next_frame(fv, fc);
    chk("window", {vld, cnt[CB-1:0], adr[AB-1:0]}, {4'b0001, 3'd6, 11'd10});
    fv = '0; fc = '0;
    set_pad(6, 2); set_pad(9, 3);
    next_frame(fv, fc);
    chk("frame_a", {frame_done, vld, adr[AB-1:0]}, {1'b1, 4'b0001, 11'd5});
    @(negedge clock);
    chk("strobe_one_cycle", 64'(frame_done), 64'd0);

    // Frame with pad 33, abandoned by a reset at phase 4.
    fv = '0; fc = '0;
    set_pad(33, 4);
    next_frame(fv, fc);
    chk("frame_b", 64'({vld, adr[3*AB-1:0]}), 64'({4'b0011, INV, 11'd9, 11'd6}));
    wait_phase(4);
    global_reset = 1'b1;
    @(negedge clock);
    global_reset = 1'b0;
    chk("midreset_adr", 64'(adr), 64'({NC{INV}}));
    chk("midreset_misc", {vld, cnt, frame_done, overflow}, '0);

    // First post-reset frame.
    fv = '0; fc = '0;
    set_pad(44, 7);
    next_frame(fv, fc);
    chk("post_reset_no_strobe", 64'(frame_done), 64'd0);
    next_frame('0, '0);
    chk("post_reset_publish", {frame_done, vld, cnt[CB-1:0], adr[AB-1:0]}, {1'b1, 4'b0001, 3'd7, 11'd44});

    repeat (PH + 2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard time bound.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

endmodule
